dht_frame_encoder: RTL and testbench
====================================

// Module: dht_frame_encoder
// PURPOSE
//  Sits downstream of the DHT11 reader and upstream of the UART transmitter in top_secure_sensor.
//  Takes a 40-bit DHT frame, verifies its checksum and converts the integer parts to decimal.
//  Streams an ASCII record "T=ttt,H=hhh\r\n" byte-by-byte over a valid/ready link to the UART TX.
//  A bad frame emits "ERR\r\n" and increments a saturating error counter.
// PARAMETERS
//  ERR_CNT_W  8  width of chk_err_cnt (saturates at all-ones)
//  EOL_CR     1  1: line ends "\r\n" (0x0D,0x0A); 0: line ends "\n" only
// PORTS
//  clk          in   1   system clock (100 MHz)
//  rst          in   1   reset, asynchronous, active-low
//  frame_valid  in   1   frame_data valid; sampled only when frame_ready=1
//  frame_data   in   40  {hum_int,hum_dec,temp_int,temp_dec,checksum}, MSB first
//  frame_ready  out  1   high in IDLE only
//  tx_data      out  8   ASCII byte to UART TX
//  tx_valid     out  1   tx_data valid
//  tx_ready     in   1   UART TX accepts byte (transfer = tx_valid & tx_ready at posedge)
//  busy         out  1   ~frame_ready
//  overrun      out  1   1-cycle pulse: frame_valid=1 while frame_ready=0 (frame dropped)
//  chk_err_cnt  out  ERR_CNT_W  count of checksum-failed frames
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE; tx_valid=0, tx_data=0, overrun=0, chk_err_cnt=0, frame_ready=1.
//  Reset mid-record aborts the record immediately; partial output is not resumed.
//  FSM: IDLE -> CHECK -> CONV -> SEND -> IDLE; CHECK -> SEND (error record) on mismatch.
//   IDLE : on frame_valid, latch frame_data (cycle 0) -> CHECK.
//   CHECK: 1 cycle; ok iff (b0+b1+b2+b3) mod 256 == b4 (8-bit wrap add).
//          Mismatch: chk_err_cnt+=1 unless all-ones; select "ERR"+EOL -> SEND.
//   CONV : double-dabble, temp_int and hum_int in parallel, exactly 8 cycles -> 3 BCD digits each.
//   SEND : byte index counter walks the record; tx_valid=1 from the first SEND cycle.
//          tx_data/tx_valid held stable until transfer; index advances only on transfer.
//          After the last byte transfers: tx_valid=0 next cycle, -> IDLE.
//  Latency: good frame, first tx_valid=1 at cycle 10 after acceptance; error frame at cycle 2.
//  Record (EOL_CR=1): 'T','=',T2,T1,T0,',','H','=',H2,H1,H0,0x0D,0x0A = 13 bytes.
//   Digits = 0x30+BCD, leading zeros kept (5 -> "005", 255 -> "255"). Decimal bytes ignored.
//  Error record: 'E','R','R',EOL = 5 bytes (4 if EOL_CR=0).
//  A frame_valid arriving on the cycle the last byte transfers is dropped with overrun, because
//   frame_ready goes high only on the following cycle.
//  tx_ready may toggle arbitrarily; tx_valid never drops before transfer.
// CONFIGURATION
//  SENSOR_FRAME_CRC_EN defined: insert ',','C','=',X1,X0 before EOL (13 -> 18 bytes).
//   X1X0 = uppercase hex of CRC-8 (poly 0x07, init 0x00, no reflect, no xorout) over record
//   bytes 'T'..H0 (11 bytes). Computed on the fly per transferred byte, one byte per cycle.
//   Not applied to error records.
//  Undefined: no CRC logic; record as above.
// TESTING
//  1 frame {0,0,25,0,25}, tx_ready=1 -> "T=025,H=000\r\n"; first tx_valid at cycle 10; chk_err_cnt=0.
//  2 frame {40,0,255,0,39} (wrap sum) -> "T=255,H=040\r\n".
//  3 frame {0,0,25,0,24} -> "ERR\r\n"; chk_err_cnt=1. With ERR_CNT_W=2, 5 bad frames -> count 3.
//  4 tx_ready=0 for 7 cycles at byte 4 -> tx_data='5' held stable, tx_valid=1; record completes intact.
//  5 second frame_valid during SEND -> overrun=1 for 1 cycle; output stream unchanged; next IDLE
//    frame is accepted normally.
//  6 rst=0 at byte 6 -> tx_valid=0 asynchronously; after release, frame 1 yields full record.
//    With SENSOR_FRAME_CRC_EN: case 1 -> 18 bytes; C=XX must match the bench CRC-8 model.

Source files
------------

// File: rtl/dht_frame_encoder.sv
// rtl/dht_frame_encoder.sv - checks a DHT11 frame and streams "T=ttt,H=hhh" + EOL (or "ERR" + EOL) as ASCII bytes
// Define SENSOR_FRAME_CRC_EN to append ",C=XX" (CRC-8 of the record body) before EOL.
module dht_frame_encoder #(
  parameter int ERR_CNT_W = 8,
  parameter int EOL_CR    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_valid,
  input  logic [39:0]          frame_data,
  output logic                 frame_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] chk_err_cnt
);
  typedef enum logic [1:0] {IDLE, CHECK, CONV, SEND} state_t;

  localparam int EOL_LEN = (EOL_CR != 0) ? 2 : 1;
`ifdef SENSOR_FRAME_CRC_EN
  localparam int BODY_LEN = 16;
`else
  localparam int BODY_LEN = 11;
`endif
  localparam logic [4:0] BODY_START = 5'(BODY_LEN);
  localparam logic [4:0] REC_LAST   = 5'(BODY_LEN + EOL_LEN - 1);
  localparam logic [4:0] ERR_LAST   = 5'(3 + EOL_LEN - 1);

  state_t      state, state_nxt;
  logic [39:0] frame;
  logic        is_err;
  logic [2:0]  conv_cnt;
  logic [7:0]  t_bin, h_bin;
  logic [11:0] t_bcd, h_bcd, t_adj, h_adj;
  logic [4:0]  idx;
  logic [7:0]  sum, rec_byte;
  logic        xfer, last_byte;

  function automatic logic [11:0] dabble(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] digit(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  assign sum       = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
  assign t_adj     = dabble(t_bcd);
  assign h_adj     = dabble(h_bcd);
  assign xfer      = tx_valid & tx_ready;
  assign last_byte = (idx == (is_err ? ERR_LAST : REC_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_valid) state_nxt = CHECK;
      CHECK:   state_nxt = (sum == frame[7:0]) ? CONV : SEND;
      CONV:    if (conv_cnt == 3'd7) state_nxt = SEND;
      SEND:    if (xfer && last_byte) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame       <= '0;
      is_err      <= 1'b0;
      conv_cnt    <= '0;
      t_bin       <= '0;
      h_bin       <= '0;
      t_bcd       <= '0;
      h_bcd       <= '0;
      idx         <= '0;
      overrun     <= 1'b0;
      chk_err_cnt <= '0;
    end else begin
      overrun <= frame_valid & (state != IDLE);
      case (state)
        IDLE: if (frame_valid) begin
          frame    <= frame_data;
          t_bin    <= frame_data[23:16];
          h_bin    <= frame_data[39:32];
          t_bcd    <= '0;
          h_bcd    <= '0;
          conv_cnt <= '0;
          idx      <= '0;
        end
        CHECK: begin
          is_err <= (sum != frame[7:0]);
          if (sum != frame[7:0] && chk_err_cnt != '1)
            chk_err_cnt <= chk_err_cnt + ERR_CNT_W'(1);
        end
        CONV: begin
          // one shift-and-add-3 step per cycle; 8 steps consume the 8-bit value
          t_bcd    <= {t_adj[10:0], t_bin[7]};
          h_bcd    <= {h_adj[10:0], h_bin[7]};
          t_bin    <= {t_bin[6:0], 1'b0};
          h_bin    <= {h_bin[6:0], 1'b0};
          conv_cnt <= conv_cnt + 3'd1;
        end
        SEND: if (xfer) idx <= idx + 5'd1;
        default: ;
      endcase
    end
  end

`ifdef SENSOR_FRAME_CRC_EN
  logic [7:0] crc;

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    return r;
  endfunction

  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  // CRC covers the transferred bytes 'T'..H0; it is complete before the hex digits go out
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                   crc <= '0;
    else if (state == IDLE)                     crc <= '0;
    else if (xfer && !is_err && idx < 5'd11)    crc <= crc8(crc, tx_data);
  end
`endif

  always_comb begin
    frame_ready = (state == IDLE);
    busy        = (state != IDLE);
    tx_valid    = (state == SEND);
    rec_byte    = 8'h0A;
    if (is_err) begin
      case (idx)
        5'd0:       rec_byte = "E";
        5'd1, 5'd2: rec_byte = "R";
        default:    rec_byte = (EOL_CR != 0 && idx == 5'd3) ? 8'h0D : 8'h0A;
      endcase
    end else begin
      case (idx)
        5'd0:    rec_byte = "T";
        5'd1:    rec_byte = "=";
        5'd2:    rec_byte = digit(t_bcd[11:8]);
        5'd3:    rec_byte = digit(t_bcd[7:4]);
        5'd4:    rec_byte = digit(t_bcd[3:0]);
        5'd5:    rec_byte = ",";
        5'd6:    rec_byte = "H";
        5'd7:    rec_byte = "=";
        5'd8:    rec_byte = digit(h_bcd[11:8]);
        5'd9:    rec_byte = digit(h_bcd[7:4]);
        5'd10:   rec_byte = digit(h_bcd[3:0]);
`ifdef SENSOR_FRAME_CRC_EN
        5'd11:   rec_byte = ",";
        5'd12:   rec_byte = "C";
        5'd13:   rec_byte = "=";
        5'd14:   rec_byte = hex(crc[7:4]);
        5'd15:   rec_byte = hex(crc[3:0]);
`endif
        default: rec_byte = (EOL_CR != 0 && idx == BODY_START) ? 8'h0D : 8'h0A;
      endcase
    end
    tx_data = tx_valid ? rec_byte : 8'h00;
  end
endmodule

// File: tb/tb_dht_frame_encoder.sv
// tb/tb_dht_frame_encoder.sv - directed bench for dht_frame_encoder
module tb_dht_frame_encoder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_valid = 1'b0;
  logic [39:0] frame_data = '0;
  logic        tx_ready = 1'b1;
  logic        frame_ready, tx_valid, busy, overrun;
  logic [7:0]  tx_data, chk_err_cnt;

  logic        f2_valid = 1'b0;
  logic [39:0] f2_data = '0;
  logic        f2_ready, f2_tx_valid, f2_busy, f2_overrun;
  logic [7:0]  f2_tx_data;
  logic [1:0]  f2_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] got[$];
  int lat;
  logic [7:0] stall_byte;

  localparam logic [39:0] FRAME1 = {8'd0, 8'd0, 8'd25, 8'd0, 8'd25};
  localparam logic [39:0] FRAME2 = {8'd40, 8'd0, 8'd255, 8'd0, 8'd39};
  localparam logic [39:0] FRAME_BAD = {8'd0, 8'd0, 8'd25, 8'd0, 8'd24};

  dht_frame_encoder dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .frame_data(frame_data),
    .frame_ready(frame_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overrun(overrun), .chk_err_cnt(chk_err_cnt)
  );

  dht_frame_encoder #(.ERR_CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .frame_valid(f2_valid), .frame_data(f2_data),
    .frame_ready(f2_ready), .tx_data(f2_tx_data), .tx_valid(f2_tx_valid), .tx_ready(1'b1),
    .busy(f2_busy), .overrun(f2_overrun), .chk_err_cnt(f2_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] hexc(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  function automatic string exp_rec(input string body);
    string s = body;
`ifdef SENSOR_FRAME_CRC_EN
    logic [7:0] c = 8'h00;
    for (int i = 0; i < body.len(); i++) begin
      c = c ^ body[i];
      for (int b = 0; b < 8; b++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
    end
    s = $sformatf("%s,C=%c%c", s, hexc(c[7:4]), hexc(c[3:0]));
`endif
    return {s, "\015\012"};
  endfunction

  function automatic string rec_str();
    string s = "";
    foreach (got[i]) s = $sformatf("%s%c", s, got[i]);
    return s;
  endfunction

  function automatic string to_hex(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) r = $sformatf("%s%02h", r, s[i]);
    return r;
  endfunction

  // Offers a frame from IDLE and collects the record with optional stall / overrun injection
  task automatic drive_frame(input logic [39:0] f, input int stall_idx, input int stall_len,
                             input int ovr_idx);
    int cyc;
    int ovr;
    bit done;
    got.delete();
    lat = -1; ovr = 0; done = 0;
    frame_data = f; frame_valid = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    cyc = 1;
    while (cyc < 300 && !(done && (ovr == 0 || ovr == 3))) begin
      if (ovr == 1) begin
        checks++;
        if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_pulse got=%b want=1", overrun); end
        frame_valid = 1'b0; ovr = 2;
      end else if (ovr == 2) begin
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_single got=%b want=0", overrun); end
        ovr = 3;
      end
      if (tx_valid && !done) begin
        if (lat < 0) lat = cyc;
        if (stall_len > 0 && got.size() == stall_idx) begin
          stall_byte = tx_data; tx_ready = 1'b0;
          repeat (stall_len) begin
            @(posedge clk); #1; cyc++;
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== stall_byte) begin
              errors++;
              $display("FAIL stall_hold got=%b/%02h want=1/%02h", tx_valid, tx_data, stall_byte);
            end
          end
          tx_ready = 1'b1;
        end
        if (got.size() == ovr_idx && ovr == 0) begin
          frame_valid = 1'b1; frame_data = 40'hFF_FF_FF_FF_FF; ovr = 1;
        end
        got.push_back(tx_data);
      end else if (lat >= 0) done = 1;
      if (!(done && (ovr == 0 || ovr == 3))) begin @(posedge clk); #1; cyc++; end
    end
    frame_valid = 1'b0;
    if (!done) begin checks++; errors++; $display("FAIL record_timeout got=%0d bytes want=end", got.size()); end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (tx_valid !== 1'b0)     begin errors++; $display("FAIL rst_tx_valid got=%b want=0", tx_valid); end
    if (tx_data !== 8'h00)     begin errors++; $display("FAIL rst_tx_data got=%02h want=00", tx_data); end
    if (overrun !== 1'b0)      begin errors++; $display("FAIL rst_overrun got=%b want=0", overrun); end
    if (chk_err_cnt !== 8'd0)  begin errors++; $display("FAIL rst_err_cnt got=%0d want=0", chk_err_cnt); end
    if (frame_ready !== 1'b1)  begin errors++; $display("FAIL rst_frame_ready got=%b want=1", frame_ready); end
    if (busy !== 1'b0)         begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_good();
    string e;
    drive_frame(FRAME1, -1, 0, -1);
    e = exp_rec("T=025,H=000");
    checks += 3;
    if (rec_str() != e) begin errors++; $display("FAIL good_rec1 got=%s want=%s", to_hex(rec_str()), to_hex(e)); end
    if (lat != 10)      begin errors++; $display("FAIL good_latency got=%0d want=10", lat); end
    if (chk_err_cnt !== 8'd0) begin errors++; $display("FAIL good_err_cnt got=%0d want=0", chk_err_cnt); end
    drive_frame(FRAME2, -1, 0, -1);
    e = exp_rec("T=255,H=040");
    checks += 2;
    if (rec_str() != e) begin errors++; $display("FAIL wrap_rec got=%s want=%s", to_hex(rec_str()), to_hex(e)); end
    if (chk_err_cnt !== 8'd0) begin errors++; $display("FAIL wrap_err_cnt got=%0d want=0", chk_err_cnt); end
  endtask

  task automatic test_bad();
    string e;
    drive_frame(FRAME_BAD, -1, 0, -1);
    e = "ERR\015\012";
    checks += 3;
    if (rec_str() != e) begin errors++; $display("FAIL err_rec got=%s want=%s", to_hex(rec_str()), to_hex(e)); end
    if (lat != 2)       begin errors++; $display("FAIL err_latency got=%0d want=2", lat); end
    if (chk_err_cnt !== 8'd1) begin errors++; $display("FAIL err_cnt got=%0d want=1", chk_err_cnt); end
    for (int k = 1; k <= 5; k++) begin
      f2_data = FRAME_BAD; f2_valid = 1'b1;
      @(posedge clk); #1;
      f2_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      if (k == 2) begin
        checks++;
        if (f2_cnt !== 2'd2) begin errors++; $display("FAIL err_cnt_w2_two got=%0d want=2", f2_cnt); end
      end
    end
    checks++;
    if (f2_cnt !== 2'd3) begin errors++; $display("FAIL err_cnt_saturate got=%0d want=3", f2_cnt); end
  endtask

  task automatic test_stall();
    string e;
    drive_frame(FRAME1, 4, 7, -1);
    e = exp_rec("T=025,H=000");
    checks += 2;
    if (stall_byte !== 8'h35) begin errors++; $display("FAIL stall_byte got=%02h want=35", stall_byte); end
    if (rec_str() != e) begin errors++; $display("FAIL stall_rec got=%s want=%s", to_hex(rec_str()), to_hex(e)); end
  endtask

  task automatic test_overrun();
    string e;
    e = exp_rec("T=025,H=000");
    drive_frame(FRAME1, -1, 0, 3);
    checks++;
    if (rec_str() != e) begin errors++; $display("FAIL ovr_mid_rec got=%s want=%s", to_hex(rec_str()), to_hex(e)); end
    drive_frame(FRAME2, -1, 0, e.len() - 1);
    repeat (3) @(posedge clk);
    #1;
    checks += 3;
    if (rec_str() != exp_rec("T=255,H=040")) begin errors++; $display("FAIL ovr_last_rec got=%s", to_hex(rec_str())); end
    if (frame_ready !== 1'b1) begin errors++; $display("FAIL ovr_last_dropped_ready got=%b want=1", frame_ready); end
    if (tx_valid !== 1'b0)    begin errors++; $display("FAIL ovr_last_dropped_valid got=%b want=0", tx_valid); end
    drive_frame(FRAME1, -1, 0, -1);
    checks += 2;
    if (rec_str() != e) begin errors++; $display("FAIL ovr_next_rec got=%s want=%s", to_hex(rec_str()), to_hex(e)); end
    if (lat != 10)      begin errors++; $display("FAIL ovr_next_latency got=%0d want=10", lat); end
  endtask

  task automatic test_reset_mid();
    string e;
    frame_data = FRAME1; frame_valid = 1'b1; tx_ready = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin
      errors++; $display("FAIL mid_byte6 got=%b/%02h want=1/48", tx_valid, tx_data);
    end
    rst = 1'b0;
    #1;
    checks += 3;
    if (tx_valid !== 1'b0)    begin errors++; $display("FAIL mid_rst_valid got=%b want=0", tx_valid); end
    if (tx_data !== 8'h00)    begin errors++; $display("FAIL mid_rst_data got=%02h want=00", tx_data); end
    if (frame_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got=%b want=1", frame_ready); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    drive_frame(FRAME1, -1, 0, -1);
    e = exp_rec("T=025,H=000");
    checks += 2;
    if (rec_str() != e) begin errors++; $display("FAIL mid_after_rec got=%s want=%s", to_hex(rec_str()), to_hex(e)); end
    if (chk_err_cnt !== 8'd0) begin errors++; $display("FAIL mid_after_err_cnt got=%0d want=0", chk_err_cnt); end
  endtask

  initial begin
    test_reset();
    test_good();
    test_bad();
    test_stall();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
